mem_port_arbiter: RTL and testbench

Shares one port of the dual-port byte-enabled data memory between `N_REQ` requesters, for example the CPU load/store unit, a DMA engine and the debug module. It uses round-robin arbitration and a valid/ready request handshake, and returns responses in fixed-latency order. Requests with a misaligned address, an out-of-range address or an empty byte enable are rejected: they are not issued to memory and are answered with an error flag. The block sits between the requesters and memory port B; port A remains dedicated to instruction fetch.

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/mem_port_arbiter_rr_arbiter.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port B arbiter.
// Request bundle, pipeline tag and request legality check.
package mem_arb_pkg;

  localparam int MEM_BYTES_DEF = 8192;
  localparam int REQ_AW = 64;
  localparam int ID_W = 3;

  typedef struct packed {
    logic [REQ_AW-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              we;
  } mem_req_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
    logic            we;
  } mem_pipe_t;

  function automatic logic req_bad(
    input logic [REQ_AW-1:0] addr,
    input logic [3:0]        be,
    input int unsigned       bytes
  );
    logic [REQ_AW-1:0] top;
    top = REQ_AW'(bytes - 32'd4);
    return (addr[1:0] != 2'b00) ||
           (addr > top) ||
           (be == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Rotating-priority requester select.
// Pointer moves just past the last winner.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int GW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [GW-1:0]    gnt_id
);

  logic [GW-1:0]      rr_ptr;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [GW:0]        sum;
  logic               hit;

  // first valid requester at or after rr_ptr wins
  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[N_REQ-1:0];
    sum = '0;
    hit = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        sum = (GW+1)'(rr_ptr) + (GW+1)'(k);
      end
    end
    if (sum >= (GW+1)'(N_REQ))
      sum = sum - (GW+1)'(N_REQ);
    gnt_id = sum[GW-1:0];
    gnt = hit ? (N_REQ'(1) << gnt_id) : '0;
  end

  // advance the pointer past each winner, wrapping at N_REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hit) begin
      if (gnt_id == GW'(N_REQ - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= gnt_id + GW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of data-memory port B.
// Accept, issue, respond; illegal requests answered with err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*32-1:0]     req_wdata,
  input  logic [N_REQ*4-1:0]      req_be,
  input  logic [N_REQ-1:0]        req_we,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_REQ-1:0]        rsp_err,
  output logic [31:0]             rsp_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_data_i,
  output logic [3:0]              mem_data_en,
  output logic                    mem_write_en,
  input  logic [31:0]             mem_data_o
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] live;
  logic [N_REQ-1:0] gnt;
  logic [GW-1:0]    gnt_id;
  logic             take;
  mem_req_t         sel;
  logic             sel_err;
  mem_pipe_t        iss;
  logic             rd_ok;

  assign live = req_valid & {N_REQ{rst_n}};

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (live),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign take = |gnt;

  // pick the winner's fields and judge legality
  always_comb begin
    sel = '0;
    sel.addr = REQ_AW'(req_addr[int'(gnt_id)*ADDR_W +: ADDR_W]);
    sel.wdata = req_wdata[int'(gnt_id)*32 +: 32];
    sel.be = req_be[int'(gnt_id)*4 +: 4];
    sel.we = req_we[gnt_id];
    sel_err = req_bad(sel.addr, sel.be, MEM_BYTES);
  end

  // issue stage: drive memory only for legal accepted requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss <= '0;
      mem_addr <= '0;
      mem_data_i <= '0;
      mem_data_en <= '0;
      mem_write_en <= 1'b0;
    end else begin
      iss.valid <= take;
      iss.id <= ID_W'(gnt_id);
      iss.err <= sel_err;
      iss.we <= sel.we;
      if (take && !sel_err) begin
        mem_addr <= sel.addr[ADDR_W-1:0];
        mem_data_i <= sel.wdata;
        mem_data_en <= sel.be;
        mem_write_en <= sel.we;
      end else begin
        mem_data_en <= '0;
        mem_write_en <= 1'b0;
      end
    end
  end

  // response stage: one-hot flags one cycle after issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_err <= '0;
      rd_ok <= 1'b0;
    end else begin
      rsp_valid <= iss.valid ? (N_REQ'(1) << iss.id) : '0;
      rsp_err <= (iss.valid && iss.err) ?
                 (N_REQ'(1) << iss.id) : '0;
      rd_ok <= iss.valid && !iss.err && !iss.we;
    end
  end

  // memory registers its read data, so gate it by the
  // registered good-read flag rather than re-registering
  assign rsp_rdata = rd_ok ? mem_data_o : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-enabled
// synchronous memory model on port B.
module tb_mem_port_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_be;
  logic [N-1:0]  req_we;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_err;
  logic [31:0]   rsp_rdata;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data_i;
  logic [3:0]    mem_data_en;
  logic          mem_write_en;
  logic [31:0]   mem_data_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_REQ     (N),
    .MEM_BYTES (8192),
    .ADDR_W    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .req_we       (req_we),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_data_i   (mem_data_i),
    .mem_data_en  (mem_data_en),
    .mem_write_en (mem_write_en),
    .mem_data_o   (mem_data_o)
  );

  logic [31:0] mem [2048];
  logic [31:0] w;

  always @(posedge clk) begin
    if (mem_data_en != 4'b0000) begin
      if (mem_write_en) begin
        w = mem[mem_addr[12:2]];
        for (int b = 0; b < 4; b++)
          if (mem_data_en[b])
            w[b*8 +: 8] = mem_data_i[b*8 +: 8];
        mem[mem_addr[12:2]] <= w;
      end else begin
        mem_data_o <= mem[mem_addr[12:2]];
      end
    end
  end

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [12];
  int applied = 0;
  int miscompares = 0;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be,
                         input logic we);
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req_be[i*4 +: 4] = be;
    req_we[i] = we;
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    logic [N-1:0] oh;
    oh = '0;
    oh[v.id] = 1'b1;
    set_req(v.id, v.addr, v.wdata, v.be, v.we);
    req_valid = oh;
    @(negedge clk);
    check($sformatf("v%0d ready", n), req_ready, oh);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check($sformatf("v%0d mem_en", n),
          {mem_data_en, mem_write_en},
          v.err ? 5'b0 : {v.be, v.we});
    if (!v.err)
      check($sformatf("v%0d mem_addr", n), mem_addr, v.addr);
    @(negedge clk);
    check($sformatf("v%0d rsp_valid", n), rsp_valid, oh);
    check($sformatf("v%0d rsp_err", n), rsp_err,
          v.err ? oh : 3'b000);
    check($sformatf("v%0d rsp_rdata", n), rsp_rdata, v.rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{0, 32'h0008, 32'hDEADC0DE, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{1, 32'h0008, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEADC0DE};
    vt[2]  = '{2, 32'h0002, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0};
    vt[3]  = '{0, 32'h2000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0};
    vt[4]  = '{1, 32'h0010, 32'h5, 4'h0, 1'b1, 1'b1, 32'h0};
    vt[5]  = '{2, 32'h1FFC, 32'h55667788, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{0, 32'h1FFC, 32'h0, 4'hF, 1'b0, 1'b0, 32'h55667788};
    vt[7]  = '{1, 32'h02F0, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[8]  = '{2, 32'h02F0, 32'hAAFFAAFF, 4'hA, 1'b1, 1'b0, 32'h0};
    vt[9]  = '{0, 32'h02F0, 32'h0, 4'hF, 1'b0, 1'b0, 32'hAA22AA44};
    vt[10] = '{1, 32'h1FFD, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0};
    vt[11] = '{2, 32'h2000, 32'h77, 4'hF, 1'b1, 1'b1, 32'h0};

    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    for (int i = 0; i < N; i++) mem[64+i] = 32'hA000_0000 + i;

    req_valid = '0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    req_we = '0;

    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    #1 check("ready_in_reset", req_ready, 3'b000);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_ctrl",
            {req_ready, rsp_valid, rsp_err,
             mem_data_en, mem_write_en}, 64'h0);
      check("idle_data", {rsp_rdata, mem_addr}, 64'h0);
      check("idle_wdata", mem_data_i, 64'h0);
    end

    // all three requesters valid: grants rotate from 0
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      set_req(i, 32'h100 + 32'(4*i), 32'h0, 4'hF, 1'b0);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6)
        check($sformatf("rot%0d ready", k), req_ready,
              3'b001 << (k % N));
      if (k >= 2) begin
        check($sformatf("rot%0d rsp_valid", k), rsp_valid,
              3'b001 << ((k - 2) % N));
        check($sformatf("rot%0d rdata", k), rsp_rdata,
              32'hA000_0000 + 32'((k - 2) % N));
      end
      @(posedge clk);
      #1;
      if (k == 5) req_valid = '0;
    end

    for (int n = 0; n < 12; n++) apply_vec(vt[n], n);

    // write then read of same word on consecutive accepts
    set_req(0, 32'h20, 32'h12345678, 4'hF, 1'b1);
    req_valid = 3'b001;
    @(posedge clk);
    #1 req_valid = '0;
    set_req(1, 32'h20, 32'h0, 4'hF, 1'b0);
    req_valid = 3'b010;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("raw wr_ack", {rsp_valid, rsp_err, rsp_rdata},
          {3'b001, 3'b000, 32'h0});
    @(negedge clk);
    check("raw rd", {rsp_valid, rsp_err, rsp_rdata},
          {3'b010, 3'b000, 32'h12345678});
    @(posedge clk);
    #1;

    // lone requester held valid is granted every cycle
    set_req(1, 32'h104, 32'h0, 4'hF, 1'b0);
    req_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("solo%0d ready", k), req_ready, 3'b010);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset with two requests in flight
    set_req(0, 32'h100, 32'h0, 4'hF, 1'b0);
    req_valid = 3'b001;
    @(posedge clk);
    #1 req_valid = '0;
    set_req(1, 32'h104, 32'h0, 4'hF, 1'b0);
    req_valid = 3'b010;
    @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst rsp", {rsp_valid, rsp_err}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d", k),
            {rsp_valid, rsp_err, mem_data_en}, 10'b0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      set_req(i, 32'h100 + 32'(4*i), 32'h0, 4'hF, 1'b0);
    req_valid = '1;
    @(negedge clk);
    check("post_rst first gnt", req_ready, 3'b001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst second gnt", req_ready, 3'b010);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
